// File: rtl/hls_macc_pkg.sv
// ============================================================================
// Module : hls_macc_pkg
// Brief  : Shared widths, record sizing and FSM states for the MACC result path.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package hls_macc_pkg;

    localparam int HLS_MACC_DW    = 32;
    localparam int HLS_MACC_SEQ_W = 8;

    // Record layout is {seq, out31, out30, out13}.
    function automatic int rec_width(input int dw, input int seq_w);
        return seq_w + 3 * dw;
    endfunction

    localparam int HLS_MACC_REC_W = rec_width(HLS_MACC_DW, HLS_MACC_SEQ_W);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/hls_macc_res_fifo.sv
// ============================================================================
// Module : hls_macc_res_fifo
// Brief  : Synchronous FIFO; push and pop in the same cycle are accepted at full.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hls_macc_res_fifo #(
    parameter int WIDTH = 104,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              w_wr;
    logic              w_rd;

    always_comb begin
        w_rd     = i_pop & ~o_empty;
        // A pop in the same cycle frees the head slot, so a full FIFO can still take a write.
        w_wr     = i_push & (~o_full | w_rd);
        wr_ptr_d = w_wr ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = w_rd ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (w_wr && !w_rd) begin
            count_d = count_q + CNT_W'(1);
        end else if (w_rd && !w_wr) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[rd_ptr_q];
    assign o_count = count_q;
    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/hls_macc_0_result_collector.sv
// ============================================================================
// Module : hls_macc_0_result_collector
// Brief  : Tracks one MACC call, tags and buffers its outputs, owns out30 feedback.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hls_macc_0_result_collector
    import hls_macc_pkg::*;
#(
    parameter int              DW         = HLS_MACC_DW,
    parameter int              DEPTH      = 4,
    parameter int              SEQ_W      = HLS_MACC_SEQ_W,
    parameter logic [DW-1:0]   OUT30_INIT = '0
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   macc_issue,
    input  logic                   macc_ap_done,
    input  logic [DW-1:0]          out13,
    input  logic                   out13_ap_vld,
    input  logic [DW-1:0]          out30_o,
    input  logic                   out30_o_ap_vld,
    input  logic [DW-1:0]          out31,
    input  logic                   out31_ap_vld,
    output logic [DW-1:0]          out30_i,
    output logic                   start_allow,
    output logic [SEQ_W+3*DW-1:0]  res_tdata,
    output logic                   res_tvalid,
    input  logic                   res_tready,
    output logic                   err_vld_mismatch,
    output logic                   err_spurious_done,
    output logic                   err_overflow
);

    localparam int REC_W = rec_width(DW, SEQ_W);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_e            state_q, state_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [DW-1:0]     out30_q, out30_d;
    logic              err_vld_q, err_vld_d;
    logic              err_spur_q, err_spur_d;
    logic              err_ovf_q, err_ovf_d;

    logic              w_capture;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [REC_W-1:0]  w_rec;
    logic              w_all_vld;
    logic              w_any_vld;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (macc_issue)   state_d = S_WAIT;
            S_WAIT:  if (macc_ap_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_capture  = (state_q == S_WAIT) & macc_ap_done;
        w_pop      = ~w_empty & res_tready;
        w_push     = w_capture & (~w_full | w_pop);
        w_rec      = {seq_q, out31, out30_o, out13};
        w_all_vld  = out13_ap_vld & out30_o_ap_vld & out31_ap_vld;
        w_any_vld  = out13_ap_vld | out30_o_ap_vld | out31_ap_vld;

        // Sequence advances on every completed call, even when the record is dropped.
        seq_d      = w_capture ? seq_q + SEQ_W'(1) : seq_q;
        out30_d    = out30_o_ap_vld ? out30_o : out30_q;
        err_vld_d  = err_vld_q  | (macc_ap_done ? ~w_all_vld : w_any_vld);
        err_spur_d = err_spur_q | ((state_q == S_IDLE) & macc_ap_done);
        err_ovf_d  = err_ovf_q  | (w_capture & w_full & ~w_pop);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= S_IDLE;
            seq_q      <= '0;
            out30_q    <= OUT30_INIT;
            err_vld_q  <= 1'b0;
            err_spur_q <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            out30_q    <= out30_d;
            err_vld_q  <= err_vld_d;
            err_spur_q <= err_spur_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

    hls_macc_res_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .i_push  (w_push),
        .i_wdata (w_rec),
        .i_pop   (w_pop),
        .o_rdata (res_tdata),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign start_allow       = (state_q == S_IDLE) & (w_count < CNT_W'(DEPTH));
    assign res_tvalid        = ~w_empty;
    assign out30_i           = out30_q;
    assign err_vld_mismatch  = err_vld_q;
    assign err_spurious_done = err_spur_q;
    assign err_overflow      = err_ovf_q;

endmodule

`default_nettype wire
